// File: rtl/qft3_prob_argmax_pkg.sv
// Shared fixed-point widths and FSM state type for the QFT3 probability/argmax block.
// Amplitudes are S4.4 two's complement; magnitudes are unsigned r^2+i^2.
package qft3_prob_argmax_pkg;

  localparam int TOTAL_WIDTH = 8;
  localparam int FRAC_WIDTH  = 4;
  localparam int MAG_WIDTH   = 2 * TOTAL_WIDTH;
  localparam int SUM_WIDTH   = MAG_WIDTH + 3;
  localparam int NUM_STATES  = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/qft3_prob_argmax_cmag_sq.sv
// Combinational squared magnitude of one signed complex amplitude.
// Operands are sign-extended to MAG_W first, so the products never need more than MAG_W bits.
module cmag_sq
  import qft3_prob_argmax_pkg::*;
#(
  parameter int W  = TOTAL_WIDTH,
  parameter int MW = 2 * TOTAL_WIDTH
) (
  input  logic signed [W-1:0]  re,
  input  logic signed [W-1:0]  im,
  output logic        [MW-1:0] mag
);

  logic signed [MW-1:0] re_x_s;
  logic signed [MW-1:0] im_x_s;
  logic signed [MW-1:0] re_sq_s;
  logic signed [MW-1:0] im_sq_s;

  assign re_x_s  = {{(MW-W){re[W-1]}}, re};
  assign im_x_s  = {{(MW-W){im[W-1]}}, im};
  assign re_sq_s = re_x_s * re_x_s;
  assign im_sq_s = im_x_s * im_x_s;
  // Each square is at most 2^(2W-2), so the unsigned sum fits MW bits exactly.
  assign mag     = $unsigned(re_sq_s) + $unsigned(im_sq_s);

endmodule

// File: rtl/qft3_prob_argmax.sv
// Scans the eight QFT output amplitudes through one magnitude unit, accumulating the total
// and tracking the strictly largest magnitude; the result is offered on a valid/ready port.
module qft3_prob_argmax
  import qft3_prob_argmax_pkg::*;
#(
  parameter int TOTAL_W = TOTAL_WIDTH,
  parameter int MAG_W   = MAG_WIDTH,
  parameter int SUM_W   = SUM_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [TOTAL_W-1:0] f000_r,
  input  logic signed [TOTAL_W-1:0] f000_i,
  input  logic signed [TOTAL_W-1:0] f001_r,
  input  logic signed [TOTAL_W-1:0] f001_i,
  input  logic signed [TOTAL_W-1:0] f010_r,
  input  logic signed [TOTAL_W-1:0] f010_i,
  input  logic signed [TOTAL_W-1:0] f011_r,
  input  logic signed [TOTAL_W-1:0] f011_i,
  input  logic signed [TOTAL_W-1:0] f100_r,
  input  logic signed [TOTAL_W-1:0] f100_i,
  input  logic signed [TOTAL_W-1:0] f101_r,
  input  logic signed [TOTAL_W-1:0] f101_i,
  input  logic signed [TOTAL_W-1:0] f110_r,
  input  logic signed [TOTAL_W-1:0] f110_i,
  input  logic signed [TOTAL_W-1:0] f111_r,
  input  logic signed [TOTAL_W-1:0] f111_i,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2:0]                max_idx,
  output logic [MAG_W-1:0]          max_mag,
  output logic [SUM_W-1:0]          total_mag,
  output logic                      all_zero
);

  state_t                         state_r;
  logic [2:0]                     cnt_r;
  logic [NUM_STATES-1:0][TOTAL_W-1:0] cap_re_r;
  logic [NUM_STATES-1:0][TOTAL_W-1:0] cap_im_r;
  logic [SUM_W-1:0]               acc_r;
  logic [MAG_W-1:0]               best_mag_r;
  logic [2:0]                     best_idx_r;

  logic signed [TOTAL_W-1:0]      sel_re_s;
  logic signed [TOTAL_W-1:0]      sel_im_s;
  logic [MAG_W-1:0]               mag_s;
  logic [SUM_W-1:0]               acc_nxt_s;
  logic [MAG_W-1:0]               best_mag_nxt_s;
  logic [2:0]                     best_idx_nxt_s;

  cmag_sq #(.W(TOTAL_W), .MW(MAG_W)) u_cmag_sq (
    .re  (sel_re_s),
    .im  (sel_im_s),
    .mag (mag_s)
  );

  // Select the entry under scan and fold its magnitude into the running total and best.
  always_comb begin
    sel_re_s       = $signed(cap_re_r[cnt_r]);
    sel_im_s       = $signed(cap_im_r[cnt_r]);
    acc_nxt_s      = acc_r + {{(SUM_W-MAG_W){1'b0}}, mag_s};
    best_mag_nxt_s = best_mag_r;
    best_idx_nxt_s = best_idx_r;
    if (mag_s > best_mag_r) begin
      best_mag_nxt_s = mag_s;
      best_idx_nxt_s = cnt_r;
    end else begin
      best_mag_nxt_s = best_mag_r;
      best_idx_nxt_s = best_idx_r;
    end
  end

  // Control FSM with capture, scan datapath and registered handshake outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 3'd0;
      cap_re_r   <= '0;
      cap_im_r   <= '0;
      acc_r      <= '0;
      best_mag_r <= '0;
      best_idx_r <= 3'd0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      max_idx    <= 3'd0;
      max_mag    <= '0;
      total_mag  <= '0;
      all_zero   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (in_valid && in_ready) begin
            cap_re_r   <= {f111_r, f110_r, f101_r, f100_r, f011_r, f010_r, f001_r, f000_r};
            cap_im_r   <= {f111_i, f110_i, f101_i, f100_i, f011_i, f010_i, f001_i, f000_i};
            cnt_r      <= 3'd0;
            acc_r      <= '0;
            best_mag_r <= '0;
            best_idx_r <= 3'd0;
            in_ready   <= 1'b0;
            state_r    <= ST_SCAN;
          end else begin
            in_ready   <= 1'b1;
          end
        end
        ST_SCAN: begin
          acc_r      <= acc_nxt_s;
          best_mag_r <= best_mag_nxt_s;
          best_idx_r <= best_idx_nxt_s;
          cnt_r      <= cnt_r + 3'd1;
          if (cnt_r == 3'd7) begin
            max_idx   <= best_idx_nxt_s;
            max_mag   <= best_mag_nxt_s;
            total_mag <= acc_nxt_s;
            all_zero  <= (acc_nxt_s == {SUM_W{1'b0}});
            out_valid <= 1'b1;
            state_r   <= ST_DONE;
          end else begin
            state_r   <= ST_SCAN;
          end
        end
        ST_DONE: begin
          // in_ready is raised here so it is seen one cycle after the handshake edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state_r   <= ST_IDLE;
          end else begin
            out_valid <= 1'b1;
            state_r   <= ST_DONE;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_qft3_prob_argmax.sv
// Directed self-checking bench for qft3_prob_argmax: one task per scenario, hand-computed results.
module tb_qft3_prob_argmax;

  logic              clk;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic              out_valid;
  logic              out_ready;
  logic [2:0]        max_idx;
  logic [15:0]       max_mag;
  logic [18:0]       total_mag;
  logic              all_zero;
  logic signed [7:0] vr [8];
  logic signed [7:0] vi [8];

  int n_checks;
  int n_fail;

  qft3_prob_argmax dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .f000_r    (vr[0]), .f000_i (vi[0]),
    .f001_r    (vr[1]), .f001_i (vi[1]),
    .f010_r    (vr[2]), .f010_i (vi[2]),
    .f011_r    (vr[3]), .f011_i (vi[3]),
    .f100_r    (vr[4]), .f100_i (vi[4]),
    .f101_r    (vr[5]), .f101_i (vi[5]),
    .f110_r    (vr[6]), .f110_i (vi[6]),
    .f111_r    (vr[7]), .f111_i (vi[7]),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .max_idx   (max_idx),
    .max_mag   (max_mag),
    .total_mag (total_mag),
    .all_zero  (all_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_vec();
    for (int k = 0; k < 8; k++) begin
      vr[k] = 8'sd0;
      vi[k] = 8'sd0;
    end
  endtask

  // Pulses in_valid for one edge, then counts cycles until out_valid (-1 on timeout).
  task automatic launch(output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_hs: out_valid=%0b in_ready=%0b, want 0/1", out_valid, in_ready);
    end
    n_checks++;
    if (max_idx !== 3'd0 || max_mag !== 16'd0 || total_mag !== 19'd0 || all_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out: idx=%0d max=%0d tot=%0d z=%0b, want 0/0/0/0",
               max_idx, max_mag, total_mag, all_zero);
    end
  endtask

  task automatic test_qft110();
    int lat;
    clear_vec();
    vr[0] = 8'sd5;  vi[1] = -8'sd5; vr[2] = -8'sd5; vi[3] = 8'sd5;
    vr[4] = 8'sd5;  vi[5] = -8'sd5; vr[6] = -8'sd5; vi[7] = 8'sd5;
    launch(lat);
    n_checks++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL qft110_latency: got %0d cycles, want 8", lat);
    end
    n_checks++;
    if (max_idx !== 3'd0 || max_mag !== 16'd25 || total_mag !== 19'd200 || all_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL qft110_result: idx=%0d max=%0d tot=%0d z=%0b, want 0/25/200/0",
               max_idx, max_mag, total_mag, all_zero);
    end
    handshake();
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL qft110_handshake: out_valid=%0b in_ready=%0b, want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_single_peak();
    int lat;
    clear_vec();
    vr[5] = 8'sd16;
    launch(lat);
    n_checks++;
    if (lat !== 8 || max_idx !== 3'd5 || max_mag !== 16'd256 || total_mag !== 19'd256) begin
      n_fail++;
      $display("FAIL peak101: lat=%0d idx=%0d max=%0d tot=%0d, want 8/5/256/256",
               lat, max_idx, max_mag, total_mag);
    end
    handshake();
    clear_vec();
    vr[3] = 8'sd3; vi[3] = -8'sd4;
    launch(lat);
    n_checks++;
    if (lat !== 8 || max_idx !== 3'd3 || max_mag !== 16'd25 || total_mag !== 19'd25) begin
      n_fail++;
      $display("FAIL peak011: lat=%0d idx=%0d max=%0d tot=%0d, want 8/3/25/25",
               lat, max_idx, max_mag, total_mag);
    end
    handshake();
  endtask

  task automatic test_extremes();
    int lat;
    clear_vec();
    vr[7] = -8'sd128; vi[7] = -8'sd128;
    vr[0] = 8'sd127;
    launch(lat);
    n_checks++;
    if (lat !== 8 || max_idx !== 3'd7 || max_mag !== 16'd32768 || total_mag !== 19'd48897 ||
        all_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL extremes: lat=%0d idx=%0d max=%0d tot=%0d z=%0b, want 8/7/32768/48897/0",
               lat, max_idx, max_mag, total_mag, all_zero);
    end
    handshake();
  endtask

  task automatic test_back_to_back();
    int lat;
    clear_vec();
    vr[5] = 8'sd16;
    launch(lat);
    n_checks++;
    if (lat !== 8) begin
      n_fail++;
      $display("FAIL bp_latency: got %0d cycles, want 8", lat);
    end
    // Offer a different vector while the result is stalled.
    clear_vec();
    vr[3] = 8'sd6; vi[3] = 8'sd8; vr[6] = 8'sd6; vi[6] = 8'sd8;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || max_idx !== 3'd5 ||
          max_mag !== 16'd256 || total_mag !== 19'd256) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: ov=%0b ir=%0b idx=%0d max=%0d tot=%0d, want 1/0/5/256/256",
                 c, out_valid, in_ready, max_idx, max_mag, total_mag);
      end
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: out_valid=%0b in_ready=%0b, want 0/1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    n_checks++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_accept2: in_ready=%0b, want 0", in_ready);
    end
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    n_checks++;
    if (lat !== 8 || max_idx !== 3'd3 || max_mag !== 16'd100 || total_mag !== 19'd200) begin
      n_fail++;
      $display("FAIL bp_second: lat=%0d idx=%0d max=%0d tot=%0d, want 8/3/100/200",
               lat, max_idx, max_mag, total_mag);
    end
    handshake();
  endtask

  task automatic test_reset_mid_scan();
    int seen;
    clear_vec();
    vr[7] = -8'sd128; vi[7] = -8'sd128; vr[0] = 8'sd127;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    #1;
    n_checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || max_idx !== 3'd0 || max_mag !== 16'd0 ||
        total_mag !== 19'd0 || all_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL midscan_reset: ov=%0b ir=%0b idx=%0d max=%0d tot=%0d z=%0b, want 0/1/0/0/0/0",
               out_valid, in_ready, max_idx, max_mag, total_mag, all_zero);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); #1;
      if (out_valid || !in_ready) seen++;
    end
    n_checks++;
    if (seen !== 0) begin
      n_fail++;
      $display("FAIL midscan_spurious: %0d cycles with activity, want 0", seen);
    end
  endtask

  task automatic test_ties_and_zeros();
    int lat;
    clear_vec();
    vr[3] = 8'sd6; vi[3] = 8'sd8; vr[6] = 8'sd6; vi[6] = 8'sd8;
    launch(lat);
    n_checks++;
    if (lat !== 8 || max_idx !== 3'd3 || max_mag !== 16'd100 || total_mag !== 19'd200 ||
        all_zero !== 1'b0) begin
      n_fail++;
      $display("FAIL ties: lat=%0d idx=%0d max=%0d tot=%0d z=%0b, want 8/3/100/200/0",
               lat, max_idx, max_mag, total_mag, all_zero);
    end
    handshake();
    clear_vec();
    launch(lat);
    n_checks++;
    if (lat !== 8 || max_idx !== 3'd0 || max_mag !== 16'd0 || total_mag !== 19'd0 ||
        all_zero !== 1'b1) begin
      n_fail++;
      $display("FAIL zeros: lat=%0d idx=%0d max=%0d tot=%0d z=%0b, want 8/0/0/0/1",
               lat, max_idx, max_mag, total_mag, all_zero);
    end
    handshake();
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    clear_vec();
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    test_qft110();
    test_single_peak();
    test_extremes();
    test_back_to_back();
    test_reset_mid_scan();
    test_ties_and_zeros();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/qft3_prob_argmax.md
Name: qft3_prob_argmax

Overview:
- Downstream consumer of the pipelined 3-qubit QFT core; takes its eight complex S4.4 output amplitudes (f000..f111).
- Computes each state's squared magnitude (unnormalised probability), the total, and the most-probable basis index.
- Uses one time-multiplexed magnitude unit scanned by an FSM; results are offered on a valid/ready handshake to the readout/measurement logic.

Parameters:
- TOTAL_WIDTH, 8 (`TOTAL_WIDTH from shared header), amplitude word width, two's complement S4.4.
- MAG_W, 2*TOTAL_WIDTH, unsigned squared-magnitude width (r²+i² max 32768 fits 16 bits).
- SUM_W, MAG_W+3, unsigned width of the eight-term sum.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  amplitude vector valid.
- in_ready  out  1  block can accept a vector.
- f000_r, f000_i … f111_r, f111_i  in  TOTAL_WIDTH each (16 ports)  signed amplitudes, index = binary suffix.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- max_idx  out  3  basis index of largest magnitude.
- max_mag  out  MAG_W  largest r²+i².
- total_mag  out  SUM_W  sum of all eight r²+i².
- all_zero  out  1  total_mag == 0.

Behaviour:
- Reset (async assert, synchronous-to-clk release): FSM=IDLE, all capture regs/accumulators/outputs 0, out_valid=0, in_ready=1.
- FSM states: IDLE, SCAN, DONE.
- IDLE: in_ready=1. Edge with in_valid&&in_ready (edge T): register all 16 inputs, cnt=0, acc=0, best_mag=0, best_idx=0 → SCAN. Inputs ignored while in_ready=0.
- SCAN: in_ready=0. At edge T+1+k (k=0..7) entry k is processed:
  - m = r*r + i*i, computed signed×signed and zero-extended to MAG_W.
  - acc += m.
  - If m > best_mag (strict), then best_mag=m and best_idx=k; ties keep the lowest index.
  - At k=7 (edge T+8): register results into the outputs → DONE.
- DONE: out_valid=1 from edge T+8 onward, i.e. 8 cycles after acceptance. Outputs hold stable until out_ready=1 is sampled.
  - On the handshake edge: out_valid=0 → IDLE; in_ready rises the following cycle (no same-edge re-accept).
- Outputs keep their last values after the handshake; they are only meaningful while out_valid=1.
- All-zero vector: max_idx=0, max_mag=0, total_mag=0, all_zero=1.
- Extreme inputs: -128 squared = 16384, no overflow in MAG_W; SUM_W cannot overflow (8×32768 = 262144 < 2^19).
- Reset asserted mid-SCAN or in DONE: immediate return to IDLE with all reset values; the partial result is discarded and never shown valid.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

Decomposition:
- Shared header fixed_point_params.vh: `TOTAL_WIDTH, `FRAC_WIDTH; add derived `MAG_WIDTH.
- FSM state encodings as localparams inside the block.
- One sub-module, cmag_sq: combinational signed r,i → unsigned r²+i² of MAG_W. It is instanced once and fed by an 8:1 mux on cnt.

Test Plan:
1. QFT|110> vector (5,0),(0,-5),(-5,0),(0,5),(5,0),(0,-5),(-5,0),(0,5) → after 8 cycles: out_valid=1, max_mag=25, total_mag=200, max_idx=0 (tie rule), all_zero=0.
2. Single peak f101=(16,0), all others 0 → max_idx=5, max_mag=256, total_mag=256; second run with f011=(3,-4), rest 0 → max_idx=3, max_mag=25.
3. Extremes f111=(-128,-128), f000=(127,0) → max_idx=7, max_mag=32768, total_mag=48897.
4. Backpressure: hold out_ready=0 for 5 cycles after out_valid; also drive a new in_valid with a different vector → outputs stable, in_ready=0, new vector not captured. Release out_ready → handshake, then in_ready=1 next cycle and the second vector is processed correctly.
5. Reset mid-SCAN: assert rst_n=0 at the 4th SCAN cycle → out_valid=0, in_ready=1, outputs 0 after release; no spurious out_valid.
6. Ties and zeros: f011 and f110 both (6,8) → max_idx=3, max_mag=100, total_mag=200. All-zero vector → all_zero=1, max_idx=0, total_mag=0.
